// File: rtl/neural_sim_pkg.sv
// Shared definitions for the neural-data sink: sample width, sample type and
// the sink's FSM state encoding.
package neural_sim_pkg;

  localparam int SAMPLE_WIDTH = 12;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } sink_state_t;

endpackage

// File: rtl/neural_sample_fifo.sv
// Synchronous first-word-fall-through FIFO. Occupancy is tracked by an explicit
// level counter, so full/empty never depend on pointer equality.
module neural_sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign empty    = (level == '0);
  assign full     = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop      = pop_req && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/neural_data_sink.sv
// Receiving end of the neural-data stream: capture FSM, saturating sample
// counter and sticky overflow flag around a FWFT sample FIFO.
module neural_data_sink
  import neural_sim_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                          CLK_ADC,
  input  logic                          RST,
  input  logic                          EN,
  input  logic [DATA_WIDTH-1:0]         DATA_IN,
  input  logic                          DATA_VALID,
  input  logic                          DATA_END,
  output logic [DATA_WIDTH-1:0]         RD_DATA,
  output logic                          RD_VALID,
  input  logic                          RD_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [CNT_WIDTH-1:0]          SAMPLE_CNT,
  output logic                          OVERFLOW,
  output logic                          DONE,
  output sink_state_t                   state_dbg
);

  // Handshake: the consumer pops the head at an edge where RD_VALID && RD_READY;
  // RD_DATA holds its value while RD_VALID && !RD_READY.

  sink_state_t state;
  logic        push;
  logic        fifo_push_ok;
  logic        fifo_full;
  logic        fifo_empty;

  // A sample in the cycle EN falls is not captured; one arriving with DATA_END is.
  assign push      = (state == ST_CAPTURE) && EN && DATA_VALID;
  assign state_dbg = state;

  neural_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK_ADC),
    .rst      (RST),
    .push     (push),
    .wr_data  (DATA_IN),
    .pop_req  (RD_READY),
    .rd_data  (RD_DATA),
    .rd_valid (RD_VALID),
    .level    (FIFO_LEVEL),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .push_ok  (fifo_push_ok)
  );

  always_ff @(posedge CLK_ADC) begin
    if (RST) begin
      state      <= ST_IDLE;
      SAMPLE_CNT <= '0;
      OVERFLOW   <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (EN) begin
            state      <= ST_CAPTURE;
            SAMPLE_CNT <= '0;
            OVERFLOW   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (push) begin
            if (fifo_push_ok) begin
              if (SAMPLE_CNT != '1) begin
                SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
              end
            end else if (fifo_full) begin
              OVERFLOW <= 1'b1;
            end
          end
          if (!EN || DATA_END) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state <= ST_DONE;
            DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!EN) begin
            state <= ST_IDLE;
            DONE  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neural_data_sink.sv
// Self-checking bench for neural_data_sink: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a queue model.
module tb_neural_data_sink;
  import neural_sim_pkg::*;

  localparam int DW    = 12;
  localparam int DEPTH = 64;
  localparam int CW    = 24;
  localparam int LW    = 7;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_end = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] sample_cnt;
  logic          overflow;
  logic          done;
  sink_state_t   state_dbg;

  int tests = 0;
  int fails = 0;

  neural_data_sink dut (
    .CLK_ADC    (clk),
    .RST        (rst),
    .EN         (en),
    .DATA_IN    (data_in),
    .DATA_VALID (data_valid),
    .DATA_END   (data_end),
    .RD_DATA    (rd_data),
    .RD_VALID   (rd_valid),
    .RD_READY   (rd_ready),
    .FIFO_LEVEL (fifo_level),
    .SAMPLE_CNT (sample_cnt),
    .OVERFLOW   (overflow),
    .DONE       (done),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // behavioural model: a queue for the buffer, a phase number for the stream
  // (0 idle, 1 capturing, 2 draining, 3 finished)
  logic [DW-1:0] m_q[$];
  int            m_cnt = 0;
  bit            m_ovf = 0;
  bit            m_done = 0;
  int            m_phase = 0;
  bit            chk_en = 0;

  always @(posedge clk) begin
    int sz;
    bit pop;
    bit push;
    if (rst) begin
      m_q.delete();
      m_cnt   = 0;
      m_ovf   = 0;
      m_phase = 0;
      chk_en  = 1;
    end else begin
      sz   = m_q.size();
      pop  = (sz > 0) && rd_ready;
      push = (m_phase == 1) && en && data_valid;
      case (m_phase)
        0: if (en) begin m_phase = 1; m_cnt = 0; m_ovf = 0; end
        1: if (!en || data_end) m_phase = 2;
        2: if (sz == 0) m_phase = 3;
        default: if (!en) m_phase = 0;
      endcase
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz < DEPTH || pop) begin
          m_q.push_back(data_in);
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_done = (m_phase == 3);
  end

  // scoreboard: per-cycle compare against the model, plus a log of popped data
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pop_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", rd_valid, m_q.size() > 0);
      check("rd_data", rd_data, (m_q.size() > 0) ? m_q[0] : '0);
      check("fifo_level", fifo_level, m_q.size());
      check("sample_cnt", sample_cnt, m_cnt);
      check("overflow", overflow, m_ovf);
      check("done", done, m_done);
      check("state", state_dbg, m_phase);
      if (rd_valid && rd_ready) pop_log.push_back(rd_data);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_sample(input logic [DW-1:0] v);
    data_in    = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic compare_log(input string name);
    check({name, "_count"}, pop_log.size(), exp_q.size());
    while (exp_q.size() > 0 && pop_log.size() > 0) begin
      check(name, pop_log.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    pop_log.delete();
  endtask

  // end the current stream, wait for DONE, return to IDLE and start a fresh one
  task automatic restart();
    int k;
    en         = 1'b0;
    data_valid = 1'b0;
    data_end   = 1'b0;
    rd_ready   = 1'b1;
    if (state_dbg != ST_IDLE) begin
      k = 0;
      while (!done && k < 300) begin
        tick();
        k++;
      end
      check("restart_done", done, 1'b1);
      tick();
    end
    check("restart_idle", state_dbg, ST_IDLE);
    en = 1'b1;
    tick();
    check("restart_capture", state_dbg, ST_CAPTURE);
    check("restart_cnt", sample_cnt, 0);
    check("restart_ovf", overflow, 1'b0);
    pop_log.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    cycles(3);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    cycles(5);
    check("idle_level", fifo_level, 0);
    check("idle_cnt", sample_cnt, 0);
    check("idle_state", state_dbg, ST_IDLE);

    // ramp -2048..-2039 with the consumer always ready
    en = 1'b1;
    tick();
    rd_ready = 1'b1;
    pop_log.delete();
    for (int i = 0; i < 10; i++) push_sample(DW'(12'h800 + i));
    cycles(3);
    for (int i = 0; i < 10; i++) exp_q.push_back(DW'(12'h800 + i));
    compare_log("ramp");
    check("ramp_cnt", sample_cnt, 10);

    // overflow: 70 samples into 64 entries with nobody reading
    restart();
    rd_ready = 1'b0;
    for (int i = 0; i < 70; i++) push_sample(DW'(i));
    check("ovf_level", fifo_level, 64);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_cnt", sample_cnt, 64);
    pop_log.delete();
    rd_ready = 1'b1;
    cycles(66);
    for (int i = 0; i < 64; i++) exp_q.push_back(DW'(i));
    compare_log("ovf_read");

    // full FIFO with a push and a pop in the same cycle
    restart();
    rd_ready = 1'b0;
    for (int i = 0; i < 64; i++) push_sample(DW'(1000 + i));
    check("full_level", fifo_level, 64);
    pop_log.delete();
    rd_ready = 1'b1;
    push_sample(DW'(100));
    check("fullrw_ovf", overflow, 1'b0);
    check("fullrw_level", fifo_level, 64);
    check("fullrw_cnt", sample_cnt, 65);
    cycles(66);
    for (int i = 1; i < 64; i++) exp_q.push_back(DW'(1000 + i));
    exp_q.push_front(DW'(1000));
    exp_q.push_back(DW'(100));
    compare_log("fullrw_read");

    // end of stream: three queued samples, then 2047 together with DATA_END
    restart();
    rd_ready = 1'b0;
    push_sample(DW'(10));
    push_sample(DW'(20));
    push_sample(DW'(30));
    data_end = 1'b1;
    push_sample(DW'(2047));
    data_end = 1'b0;
    check("eos_cnt", sample_cnt, 4);
    check("eos_level", fifo_level, 4);
    check("eos_drain", state_dbg, ST_DRAIN);
    pop_log.delete();
    rd_ready = 1'b1;
    cycles(4);
    check("eos_empty", fifo_level, 0);
    check("eos_not_done_yet", done, 1'b0);
    tick();
    check("eos_done", done, 1'b1);
    exp_q = '{DW'(10), DW'(20), DW'(30), DW'(2047)};
    compare_log("eos_read");
    en = 1'b0;
    tick();
    check("eos_idle", state_dbg, ST_IDLE);
    check("eos_done_drop", done, 1'b0);

    // reset in the middle of a capture
    en = 1'b1;
    tick();
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_sample(DW'($urandom));
    check("mid_cnt", sample_cnt, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_level", fifo_level, 0);
    check("mid_valid", rd_valid, 1'b0);
    check("mid_state", state_dbg, ST_IDLE);
    tick();
    check("mid_restart_cnt", sample_cnt, 0);
    for (int i = 0; i < 5; i++) push_sample(DW'($urandom));
    check("mid_new_cnt", sample_cnt, 5);

    // randomized traffic, checked each cycle by the model compare
    for (int blk = 0; blk < 20; blk++) begin
      int ready_pct;
      ready_pct = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        en         = ($urandom_range(0, 19) != 0);
        data_valid = ($urandom_range(0, 3) != 0);
        data_end   = ($urandom_range(0, 149) == 0);
        rd_ready   = ($urandom_range(0, 99) < ready_pct);
        data_in    = DW'($urandom);
        rst        = ($urandom_range(0, 599) == 0);
        tick();
      end
    end
    rst = 1'b0;
    data_valid = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
